// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the byte-serial instruction fetch stage.
package if_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  localparam logic            Enable   = 1'b1;
  localparam logic            Disable  = 1'b0;
  localparam logic [XLEN-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_ISSUE = 2'd0,
    IF_LAST  = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

  // Payload presented across the IF/ID boundary.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage (master) and the memory controller (slave).
interface if_fetch_if
  import if_fetch_pkg::*;
();

  logic              mem_req_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic              mem_busy_i;
  logic [BYTE_W-1:0] mem_rdata_i;

  modport master (output mem_req_o, mem_addr_o, input mem_busy_i, mem_rdata_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_busy_i, mem_rdata_i);

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads per instruction, assembled little-endian,
// held under stall, redirected by EX with in-flight bytes dropped.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_en_i,
  input  logic [XLEN-1:0] branch_target_i,
  if_fetch_if.master      mem,
  output logic [XLEN-1:0] pc_IFID_o,
  output logic [XLEN-1:0] inst_IFID_o,
  output logic            valid_IFID_o
);

  if_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  pidx_q, pidx_d;
  logic [XLEN-1:0]   byte_buf_q, byte_buf_d;
  ifid_t             ifid_q, ifid_d;
  logic              accept_c;

  // Request side is combinational so the controller sees the address in the issuing cycle.
  always_comb begin
    mem.mem_req_o  = (state_q == IF_ISSUE) && !rst;
    mem.mem_addr_o = rst ? RESET_PC : pc_q + XLEN'(cnt_q);
    accept_c       = mem.mem_req_o && !mem.mem_busy_i;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    pend_d     = Disable;
    pidx_d     = pidx_q;
    byte_buf_d = byte_buf_q;
    ifid_d     = ifid_q;

    if (pend_q) begin
      byte_buf_d[BYTE_W*pidx_q +: BYTE_W] = mem.mem_rdata_i;
    end

    unique case (state_q)
      IF_ISSUE: begin
        if (accept_c) begin
          pend_d = Enable;
          pidx_d = cnt_q;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) state_d = IF_LAST;
        end
      end
      IF_LAST: begin
        ifid_d.inst  = {mem.mem_rdata_i, byte_buf_q[23:0]};
        ifid_d.pc    = pc_q;
        ifid_d.valid = Enable;
        state_d      = IF_HOLD;
      end
      IF_HOLD: begin
        if (!stall_i) begin
          ifid_d.valid = Disable;
          pc_d         = pc_q + XLEN'(4);
          cnt_d        = '0;
          state_d      = IF_ISSUE;
        end
      end
      default: state_d = IF_ISSUE;
    endcase

    // Redirect overrides everything, including the byte landing this cycle.
    if (branch_en_i) begin
      pc_d         = branch_target_i;
      cnt_d        = '0;
      pend_d       = Disable;
      byte_buf_d   = byte_buf_q;
      ifid_d.pc    = ifid_q.pc;
      ifid_d.inst  = ifid_q.inst;
      ifid_d.valid = Disable;
      state_d      = IF_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_ISSUE;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      pend_q     <= Disable;
      pidx_q     <= '0;
      byte_buf_q <= ZeroWord;
      ifid_q     <= '{pc: ZeroWord, inst: ZeroWord, valid: Disable};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pidx_q     <= pidx_d;
      byte_buf_q <= byte_buf_d;
      ifid_q     <= ifid_d;
    end
  end

  assign pc_IFID_o    = ifid_q.pc;
  assign inst_IFID_o  = ifid_q.inst;
  assign valid_IFID_o = ifid_q.valid;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that sits directly upstream of the ID decoder. It reads 32-bit RISC-V instructions over the byte-wide memory-controller port, four sequential byte reads per instruction, and assembles them little-endian. It presents `{pc, inst, valid}` to the IF/ID boundary and holds them under downstream stall. It redirects on a branch/jump request from EX and discards any byte already in flight.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall_i` in 1: IF/ID cannot accept this cycle; hold the current output.
- `branch_en_i` in 1: redirect request, one cycle wide.
- `branch_target_i` in 32: redirect PC, valid when `branch_en_i`.
- `mem_req_o` out 1: byte read request.
- `mem_addr_o` out 32: byte address of the request.
- `mem_busy_i` in 1: controller refuses the request this cycle. A request is accepted iff `mem_req_o && !mem_busy_i`.
- `mem_rdata_i` in 8: read byte. Valid exactly one cycle after acceptance.
- `pc_IFID_o` out 32: PC of the presented instruction.
- `inst_IFID_o` out 32: assembled instruction.
- `valid_IFID_o` out 1: `pc_IFID_o`/`inst_IFID_o` are valid.

## Operation
- Registers:
  - `pc` (32)
  - `cnt` (2): next byte to issue
  - `pend`: a byte is due on `mem_rdata_i` this cycle
  - `pidx` (2): index of the pending byte
  - `buf` (32)
  - state
- State ISSUE:
  - Drive `mem_req_o=1` and `mem_addr_o=pc+cnt`. The add is modulo 2^32, so it wraps at `32'hFFFF_FFFF`.
  - On acceptance: set `pend<=1`, `pidx<=cnt`, `cnt<=cnt+1`. If `cnt==3`, go to LAST.
  - While refused: hold `cnt`, keep the address stable, `pend<=0`.
- State LAST: `mem_req_o=0`. Capture byte 3 into `inst_IFID_o[31:24]`, copy `buf[23:0]` to `inst_IFID_o[23:0]`, set `pc_IFID_o<=pc`, `valid_IFID_o<=1`, go to HOLD.
- State HOLD: `mem_req_o=0`. If `!stall_i`: set `valid_IFID_o<=0`, `pc<=pc+4`, `cnt<=0`, go to ISSUE. Otherwise all outputs hold.
- Capture rule: in every cycle with `pend==1`, `mem_rdata_i` is written to `buf[8*pidx +: 8]`. The only exception is a redirect edge (see below).
- Byte order is little-endian: byte at `pc+k` lands in `inst[8k+7:8k]`.
- Redirect: `branch_en_i==1` at an edge, in any state:
  - `pc<=branch_target_i`, `cnt<=0`, `pend<=0`, `valid_IFID_o<=0`, state<=ISSUE.
  - Any byte arriving the next cycle is ignored.
  - Redirect has priority over `stall_i`, over acceptance, and over the LAST→HOLD transition.
- Targets are not alignment-checked; fetch proceeds byte-wise from any address.
- When `mem_req_o==0`, `mem_addr_o` still shows `pc+cnt`. The controller must qualify it with `mem_req_o`.

## Timing
- Reset values: `pc=RESET_PC`, `cnt=0`, `pend=0`, `buf=0`, state=ISSUE, `pc_IFID_o=0`, `inst_IFID_o=32'h0` (ZeroWord), `valid_IFID_o=0`.
  - `mem_req_o` is forced to 0 in any cycle where `rst==1`.
  - `mem_addr_o=RESET_PC` during reset.
- `rst` asserted mid-fetch or mid-hold: everything returns to reset values on that edge; in-flight bytes are dropped.
- Unstalled, never-busy latency, with cycle 0 the first cycle after `rst` falls:
  - Requests for `pc..pc+3` in cycles 0-3.
  - LAST in cycle 4.
  - `valid_IFID_o=1` in cycle 5.
  - Next request `pc+4` in cycle 6.
  - Throughput: one instruction per 6 cycles.
- Each busy cycle adds exactly one cycle. Busy never corrupts `buf`.
- Redirect at edge t: `mem_req_o=1` with `mem_addr_o=branch_target_i` in cycle t+1 (first cycle after the edge); `valid_IFID_o=0` from t+1.
- `valid_IFID_o` deasserts the cycle after the handoff edge (HOLD with `!stall_i`). The IF/ID register samples on that edge.

## Structure
- Shared macro header: `Enable`/`Disable`, `ZeroWord`, state encodings `IF_ISSUE`/`IF_LAST`/`IF_HOLD` (2-bit).
- No sub-module; the byte assembler is a few lines inside the stage.
- All state in one clocked block. `mem_req_o`/`mem_addr_o` are combinational from state, `pc`, `cnt`, `rst`.

## Test plan
- Reset release, mem at 0..3 = `13 05 50 00`, never busy:
  - Addresses 0,1,2,3 in cycles 0-3.
  - Cycle 5: `valid=1`, `pc_IFID_o=0`, `inst_IFID_o=32'h0050_0513`.
  - Cycle 6: `mem_addr_o=4`.
- `mem_busy_i` high for 2 cycles on byte 2: address 2 held stable during those cycles; `valid` in cycle 7; instruction identical to the no-busy case.
- `stall_i` high for 3 cycles from the first valid cycle: outputs frozen for 4 cycles, no `mem_req_o`; request for `pc+4` the cycle after `stall_i` falls.
- `branch_en_i` with target `32'h100` in the cycle byte 1 is accepted:
  - Next cycle `mem_addr_o=32'h100`.
  - Stale byte ignored.
  - Presented `pc_IFID_o=32'h100` with bytes from `0x100..0x103` only.
- Branch asserted together with `stall_i` while HOLD is valid: `valid` drops next cycle, fetch resumes at the target.
- `RESET_PC=32'hFFFF_FFFE`: addresses FFFE, FFFF, 0, 1 (32-bit wrap). `rst` pulsed during byte 2 returns all outputs to reset values the next cycle.
